sfa_5to1_rr_arbiter: RTL and testbench

- Round-robin arbiter that drives the CONF select of the SFA 5-to-1 AXI-Stream mux, sharing its single master output among five slave streams.
- Watches the five source tvalid lines and the mux-output handshake.
- Grants one source at a time for a bounded burst, or until that source goes idle.
- A software-driven fixed-route mode bypasses arbitration.

---
 rtl/sfa_5to1_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_sfa_5to1_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfa_5to1_rr_arbiter.sv
// rtl/sfa_5to1_rr_arbiter.sv - round-robin CONF select driver for the SFA 5-to-1 stream mux
// Grants one source per bounded burst, releases on burst count or idle timeout, with a fixed-route bypass.
module sfa_5to1_rr_arbiter #(
  parameter int BURST_LEN    = 16,
  parameter int CNT_W        = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [4:0] s_tvalid,
  input  logic       mO_tvalid,
  input  logic       mO_tready,
  input  logic       EN,
  input  logic       FIXED_EN,
  input  logic [3:0] FIXED_CONF,
  output logic [3:0] CONF,
  output logic       grant_active,
  output logic       release_pulse,
  output logic       release_cause
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_FIXED} state_t;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]   IDLE_LIMIT = (CNT_W + 1)'(IDLE_TIMEOUT);

  state_t           state_q;
  logic [3:0]       conf_q;
  logic             grant_q;
  logic             pulse_q;
  logic             cause_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] idle_q, idle_d;

  logic       beat;
  logic       any_req;
  logic       gnt_valid;
  logic       fixed_ok;
  logic       burst_hit;
  logic       idle_hit;
  logic [2:0] win;
  logic [3:0] cand;

  // Descending scan so the candidate closest after the pointer is the final assignment.
  always_comb begin
    win  = 3'd0;
    cand = 4'd0;
    for (int i = 5; i >= 1; i--) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand > 4'd5) cand = cand - 4'd5;
      if (s_tvalid[3'(cand - 4'd1)]) win = cand[2:0];
    end
  end

  always_comb begin
    beat      = mO_tvalid & mO_tready;
    any_req   = |s_tvalid;
    fixed_ok  = (FIXED_CONF >= 4'd1) && (FIXED_CONF <= 4'd5);
    gnt_valid = ((conf_q >= 4'd1) && (conf_q <= 4'd5)) ? s_tvalid[3'(conf_q - 4'd1)] : 1'b0;
    burst_hit = beat && (burst_q == BURST_LAST);
    idle_hit  = (IDLE_TIMEOUT > 0) && !beat && !gnt_valid &&
                (({1'b0, idle_q} + 1'b1) >= IDLE_LIMIT);
    burst_d   = beat ? burst_q + 1'b1 : burst_q;
    if (beat)            idle_d = '0;
    else if (!gnt_valid) idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    else                 idle_d = idle_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      conf_q  <= 4'd0;
      grant_q <= 1'b0;
      pulse_q <= 1'b0;
      cause_q <= 1'b0;
      ptr_q   <= 3'd5;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (FIXED_EN) begin
        // Bypass wins over everything; any open burst is dropped without a pulse.
        state_q <= ST_FIXED;
        conf_q  <= fixed_ok ? FIXED_CONF : 4'd0;
        grant_q <= fixed_ok;
        burst_q <= '0;
        idle_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (EN && any_req) begin
              state_q <= ST_GRANT;
              conf_q  <= {1'b0, win};
              grant_q <= 1'b1;
              ptr_q   <= win;
              burst_q <= '0;
              idle_q  <= '0;
            end
          end
          ST_GRANT: begin
            if (burst_hit || idle_hit) begin
              pulse_q <= 1'b1;
              cause_q <= !burst_hit;
              burst_q <= '0;
              idle_q  <= '0;
              if (EN && any_req) begin
                conf_q <= {1'b0, win};
                ptr_q  <= win;
              end else begin
                state_q <= ST_IDLE;
                conf_q  <= 4'd0;
                grant_q <= 1'b0;
              end
            end else begin
              burst_q <= burst_d;
              idle_q  <= idle_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            conf_q  <= 4'd0;
            grant_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign CONF          = conf_q;
  assign grant_active  = grant_q;
  assign release_pulse = pulse_q;
  assign release_cause = cause_q;

endmodule

// File: tb/tb_sfa_5to1_rr_arbiter.sv
// tb/tb_sfa_5to1_rr_arbiter.sv - self-checking bench for sfa_5to1_rr_arbiter
// Vector table, directed corner sequences and random traffic against a cycle reference model.
module tb_sfa_5to1_rr_arbiter;
  localparam int BL = 16;
  localparam int TO = 4;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [4:0] s_tvalid = 5'b0;
  logic       mO_tvalid = 1'b0;
  logic       mO_tready = 1'b0;
  logic       EN = 1'b0;
  logic       FIXED_EN = 1'b0;
  logic [3:0] FIXED_CONF = 4'd0;
  logic [3:0] CONF;
  logic       grant_active;
  logic       release_pulse;
  logic       release_cause;

  sfa_5to1_rr_arbiter #(.BURST_LEN(BL), .CNT_W(8), .IDLE_TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_tvalid(s_tvalid), .mO_tvalid(mO_tvalid),
    .mO_tready(mO_tready), .EN(EN), .FIXED_EN(FIXED_EN), .FIXED_CONF(FIXED_CONF),
    .CONF(CONF), .grant_active(grant_active), .release_pulse(release_pulse),
    .release_cause(release_cause)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0 idle, 1 grant, 2 fixed.
  int m_mode, m_conf, m_ptr, m_beats, m_idle, m_pulse, m_cause;
  bit follow = 1'b0;

  typedef struct {
    logic [4:0] s;
    logic       en;
    logic       fen;
    logic [3:0] fc;
    logic       mv;
    logic       mr;
    logic [3:0] exp_conf;
    logic       exp_pulse;
    logic       exp_cause;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int c;
    for (int k = 1; k <= 5; k++) begin
      c = (m_ptr + k - 1) % 5 + 1;
      if (s_tvalid[c-1]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_conf = 0; m_ptr = 5; m_beats = 0; m_idle = 0; m_pulse = 0; m_cause = 0;
  endtask

  task automatic model_step();
    bit rel;
    int cause, w;
    rel = 1'b0;
    cause = 0;
    m_pulse = 0;
    if (FIXED_EN) begin
      m_mode = 2;
      m_conf = (FIXED_CONF >= 1 && FIXED_CONF <= 5) ? int'(FIXED_CONF) : 0;
      m_beats = 0;
      m_idle = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
      m_conf = 0;
    end else if (m_mode == 0) begin
      w = pick();
      if (EN && w != 0) begin
        m_mode = 1; m_conf = w; m_ptr = w; m_beats = 0; m_idle = 0;
      end
    end else begin
      if (mO_tvalid && mO_tready) begin
        if (m_beats == BL - 1) begin rel = 1'b1; cause = 0; end
        else begin m_beats++; m_idle = 0; end
      end else if (!s_tvalid[m_conf-1]) begin
        if (m_idle < 255) m_idle++;
        if (TO > 0 && m_idle >= TO) begin rel = 1'b1; cause = 1; end
      end
      if (rel) begin
        m_pulse = 1;
        m_cause = cause;
        m_beats = 0;
        m_idle = 0;
        w = pick();
        if (EN && w != 0) begin m_conf = w; m_ptr = w; end
        else begin m_mode = 0; m_conf = 0; end
      end
    end
  endtask

  task automatic step();
    if (follow) mO_tvalid = (m_conf != 0) ? s_tvalid[m_conf-1] : 1'b0;
    model_step();
    @(posedge ACLK);
    #1;
    check("conf", CONF, m_conf);
    check("grant_active", grant_active, int'(m_conf != 0));
    check("release_pulse", release_pulse, m_pulse);
    if (m_pulse != 0) check("release_cause", release_cause, m_cause);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    model_reset();
    #2;
    check("async_rst_conf", CONF, 0);
    check("async_rst_grant", grant_active, 0);
    check("async_rst_pulse", release_pulse, 0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  initial begin
    int exp_rot[5];
    exp_rot = '{2, 3, 5, 2, 3};

    model_reset();
    #12;
    check("reset_conf", CONF, 0);
    check("reset_cause", release_cause, 0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Fixed route mid-grant, resume from prior pointer, idle-timeout handover.
    vecs.push_back('{5'b00000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1});
    vecs.push_back('{5'b00000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      s_tvalid = vecs[i].s; EN = vecs[i].en; FIXED_EN = vecs[i].fen; FIXED_CONF = vecs[i].fc;
      mO_tvalid = vecs[i].mv; mO_tready = vecs[i].mr;
      step();
      check($sformatf("vec%0d_conf", i), CONF, int'(vecs[i].exp_conf));
      check($sformatf("vec%0d_pulse", i), release_pulse, int'(vecs[i].exp_pulse));
      if (vecs[i].exp_pulse) check($sformatf("vec%0d_cause", i), release_cause, int'(vecs[i].exp_cause));
    end

    // Single source burst of 16 with EN dropped mid-grant.
    do_reset();
    follow = 1'b1; s_tvalid = 5'b00001; EN = 1'b1; mO_tready = 1'b1;
    step();
    check("A_grant", CONF, 1);
    EN = 1'b0;
    for (int b = 1; b <= BL; b++) begin
      step();
      check("A_pulse", release_pulse, int'(b == BL));
      if (b == BL) begin
        check("A_cause", release_cause, 0);
        check("A_conf_end", CONF, 0);
      end
    end

    // Rotation among s2, s3, s5 with back-to-back switches.
    do_reset();
    s_tvalid = 5'b10110; EN = 1'b1; mO_tready = 1'b1;
    step();
    check("B_first", CONF, exp_rot[0]);
    for (int g = 0; g < 4; g++) begin
      for (int b = 1; b <= BL; b++) begin
        step();
        if (b == BL) begin
          check("B_switch_pulse", release_pulse, 1);
          check("B_switch_conf", CONF, exp_rot[g+1]);
        end
      end
    end
    for (int b = 0; b < 3; b++) step();

    // Asynchronous reset mid-burst, then s1 beats s5.
    do_reset();
    s_tvalid = 5'b10001;
    step();
    check("F_s1_first", CONF, 1);

    // Idle timeout hands over from s3 to s4.
    do_reset();
    s_tvalid = 5'b00100;
    step();
    check("C_grant", CONF, 3);
    for (int b = 0; b < 5; b++) step();
    s_tvalid = 5'b01000;
    for (int c = 1; c <= TO; c++) begin
      step();
      check("C_pulse", release_pulse, int'(c == TO));
      check("C_conf", CONF, (c == TO) ? 4 : 3);
      if (c == TO) check("C_cause", release_cause, 1);
    end

    // Backpressure freezes the burst count.
    do_reset();
    s_tvalid = 5'b00001; EN = 1'b1; mO_tready = 1'b1;
    step();
    EN = 1'b0;
    for (int b = 0; b < 5; b++) step();
    mO_tready = 1'b0;
    for (int b = 0; b < 10; b++) begin
      step();
      check("D_stall_pulse", release_pulse, 0);
      check("D_stall_conf", CONF, 1);
    end
    mO_tready = 1'b1;
    for (int b = 1; b <= BL - 5; b++) begin
      step();
      check("D_pulse", release_pulse, int'(b == BL - 5));
    end

    // Random traffic against the model.
    do_reset();
    follow = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 5; k++) if ($urandom_range(0, 5) == 0) s_tvalid[k] = ~s_tvalid[k];
      EN = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 60) == 0) FIXED_EN = ~FIXED_EN;
      FIXED_CONF = 4'($urandom_range(0, 7));
      mO_tready = ($urandom_range(0, 3) != 0);
      mO_tvalid = (m_conf != 0 && $urandom_range(0, 4) != 0) ? s_tvalid[m_conf-1] : 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
